// File: rtl/dot_pkg.sv
// Shared definitions for the dot-product sequencer: default widths,
// pipeline latency and the controller state encoding.
package dot_pkg;

    localparam int DEF_W        = 32;
    localparam int DEF_LEN_W    = 8;
    localparam int DEF_PIPE_LAT = 2;

    // ACCEPT takes beats, DRAIN waits for the pipeline to empty,
    // DONE presents the result until the consumer takes it.
    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/tag_delay.sv
// Shift register carrying one "valid beat" bit per cycle alongside the
// external pipeline, so the accumulator knows when pipe_c is meaningful.
module tag_delay #(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_tag,
    output logic out_tag,
    output logic busy
);

    logic [DEPTH-1:0] tag_q;

    generate
        if (DEPTH == 1) begin : g_single
            // Single stage: the tag simply waits one cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) tag_q <= '0;
                else        tag_q <= in_tag;
            end
        end else begin : g_multi
            // Shift the new tag in at bit 0; bit DEPTH-1 is the one leaving.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) tag_q <= '0;
                else        tag_q <= {tag_q[DEPTH-2:0], in_tag};
            end
        end
    endgenerate

    assign out_tag = tag_q[DEPTH-1];
    // Includes the exiting bit, so "not busy" means the final add has happened.
    assign busy    = |tag_q;

endmodule

// File: rtl/dot_seq.sv
// Dot-product sequencer: feeds operand beats to an external
// multiply-add pipeline (C = A1*B1 + A2*B2), accumulates the results
// as they emerge and hands over sum and beat count once per vector.
module dot_seq
    import dot_pkg::*;
#(
    parameter int W        = DEF_W,
    parameter int LEN_W    = DEF_LEN_W,
    parameter int PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a1,
    input  logic [W-1:0]     in_a2,
    input  logic [W-1:0]     in_b1,
    input  logic [W-1:0]     in_b2,
    input  logic             in_last,
    output logic [W-1:0]     pipe_a1,
    output logic [W-1:0]     pipe_a2,
    output logic [W-1:0]     pipe_b1,
    output logic [W-1:0]     pipe_b2,
    input  logic [W-1:0]     pipe_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic [LEN_W-1:0] out_count
);

    // One tag stage per pipeline register plus the operand register itself.
    localparam int TAG_DEPTH = PIPE_LAT + 1;

    state_e           state_q, state_d;
    logic [W-1:0]     a1_q, a2_q, b1_q, b2_q;
    logic [W-1:0]     acc_q;
    logic [LEN_W-1:0] cnt_q;
    logic             accept;
    logic             handoff;
    logic             tag_exit;
    logic             tags_busy;

    assign in_ready = (state_q == ST_ACCEPT);
    assign accept   = in_valid && in_ready;
    assign handoff  = (state_q == ST_DONE) && out_ready;

    tag_delay #(.DEPTH(TAG_DEPTH)) u_tags (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_tag  (accept),
        .out_tag (tag_exit),
        .busy    (tags_busy)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_ACCEPT;
        else        state_q <= state_d;
    end

    // Next-state logic: leave DRAIN only once every tag has left.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_ACCEPT: if (accept && in_last) state_d = ST_DRAIN;
            ST_DRAIN:  if (!tags_busy)        state_d = ST_DONE;
            ST_DONE:   if (out_ready)         state_d = ST_ACCEPT;
            default:                          state_d = ST_ACCEPT;
        endcase
    end

    // Operand registers: load the beat on acceptance, zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q <= '0;
            a2_q <= '0;
            b1_q <= '0;
            b2_q <= '0;
        end else if (accept) begin
            a1_q <= in_a1;
            a2_q <= in_a2;
            b1_q <= in_b1;
            b2_q <= in_b2;
        end else begin
            a1_q <= '0;
            a2_q <= '0;
            b1_q <= '0;
            b2_q <= '0;
        end
    end

    // Accumulator: add pipe_c only when its beat's tag leaves; cleared on handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        acc_q <= '0;
        else if (handoff)  acc_q <= '0;
        else if (tag_exit) acc_q <= acc_q + pipe_c;
    end

    // Beat counter: saturating at all-ones; cleared on handoff.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                               cnt_q <= '0;
        else if (handoff)                         cnt_q <= '0;
        else if (accept && (cnt_q != {LEN_W{1'b1}})) cnt_q <= cnt_q + 1'b1;
    end

    assign pipe_a1   = a1_q;
    assign pipe_a2   = a2_q;
    assign pipe_b1   = b1_q;
    assign pipe_b2   = b2_q;
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = acc_q;
    assign out_count = cnt_q;

endmodule
